seq_serializer: RTL and testbench
=================================

// Module: seq_serializer
// PURPOSE
//  Parallel-to-serial stage that sits directly upstream of the overlapping "101" sequence
//  detector and drives its seq_in.
//  Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock.
//  A one-word pending register keeps back-to-back words gap-free.
//  A debug state output matches the detector's style.
// PARAMETERS
//  WIDTH     8  bits per word (>=2)
//  MSB_FIRST 1  1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
//  IDLE_BIT  0  value driven on seq_out when no bit is valid
//  CNT_W     16 width of the words_sent counter
// PORTS
//  clk        in  1       single clock, rising edge
//  rst        in  1       synchronous, active-high reset
//  data_in    in  WIDTH   parallel word
//  data_valid in  1       data_in is valid
//  data_ready out 1       block can take a word; accept = data_valid & data_ready at clk edge
//  seq_out    out 1       serial bit; feeds the detector's seq_in
//  seq_valid  out 1       seq_out carries a data bit this cycle
//  busy       out 1       state != IDLE
//  words_sent out CNT_W   count of fully shifted words (wraps)
//  state_out  out 2       debug: current state encoding
// BEHAVIOUR
//  - Reset (rst=1 at edge) gives, from the next cycle:
//    - state=IDLE, pending register empty.
//    - seq_out=IDLE_BIT, seq_valid=0, data_ready=1, busy=0, words_sent=0, state_out=0.
//  - rst overrides all else, including mid-word. The active and pending words are dropped.
//  - All outputs are registered, except data_ready = ~pend_full (a register, no comb path from data_valid).
//  - States: IDLE=2'd0, SHIFT=2'd1 (shifting, pending empty), SHIFT_PEND=2'd2 (shifting, pending full).
//    2'd3 is illegal and is forced to IDLE.
//  - Latency: a word accepted at edge k drives its bits on seq_out during cycles k+1..k+WIDTH,
//    with seq_valid=1 in exactly those cycles.
//  - IDLE: accept -> load shifter, bit_cnt=WIDTH-1, go to SHIFT. No accept -> stay.
//  - SHIFT, not on the last bit:
//    - Each edge: advance one bit, bit_cnt-1.
//    - Accept -> word goes to the pending register, go to SHIFT_PEND.
//  - SHIFT, on the last bit (bit_cnt==0):
//    - words_sent+1.
//    - Accept on the same edge -> load that word straight into the shifter, stay in SHIFT (no gap).
//    - Otherwise -> IDLE; seq_valid=0 and seq_out=IDLE_BIT next cycle.
//  - SHIFT_PEND: data_ready=0, so no accept is possible.
//    - On the last bit: words_sent+1, pending -> shifter, pending empty, go to SHIFT (no gap).
//  - Throughput: continuous 1 bit/clk while the source keeps up.
//    data_ready goes low for at most WIDTH-1 cycles per pending word.
//  - words_sent wraps modulo 2^CNT_W. data_in is ignored when no accept occurs.
// STRUCTURE
//  - Shared package seq_pkg: state localparams (IDLE/SHIFT/SHIFT_PEND), state width, IDLE_BIT default.
//  - One natural sub-module, seq_piso_shreg: WIDTH-bit load/shift register.
//    Inputs load, shift, MSB_FIRST; output is the current bit.
//  - The top level holds the FSM, bit_cnt ($clog2(WIDTH) bits), the pending register and words_sent.
// TESTING (WIDTH=8 unless noted)
//  1. rst=1 for 2 cycles, then 0.
//     -> seq_valid=0, seq_out=0, data_ready=1, busy=0, state_out=0, words_sent=0.
//  2. One word 8'hA5 accepted at edge k.
//     -> seq_out=1,0,1,0,0,1,0,1 in cycles k+1..k+8, seq_valid high exactly 8 cycles.
//     -> Then IDLE, words_sent=1.
//  3. 8'hB5 then 8'hCA with data_valid held high.
//     -> 16 contiguous valid bits 10110101_11001010.
//     -> state_out=2 while 8'hCA is pending, data_ready low 7 cycles, words_sent=2.
//  4. Chain into the detector and send 8'h05.
//     -> The detector pulses detected once, in the cycle the final 1 is presented.
//  5. Send 8'hFF then 8'h00; assert rst after 3 bits.
//     -> Next cycle: seq_valid=0, data_ready=1, state_out=0, words_sent=0. The pending 8'h00 is never sent.
//  6. MSB_FIRST=0, word 8'h01.
//     -> seq_out=1 then seven 0s. Also check words_sent wrap with CNT_W=2 after 4 words -> 0.

Source files
------------

// File: rtl/seq_serializer_pkg.sv
// Shared state encoding and defaults for the word-to-bit serializer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_pkg;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE       = 2'd0,
        SHIFT      = 2'd1,
        SHIFT_PEND = 2'd2
    } state_t;

    localparam logic IDLE_BIT_DEF = 1'b0;
endpackage

// File: rtl/seq_serializer_if.sv
// Word handshake between a parallel producer and the serializer.
// Latency: n/a (wires only).
// Backpressure: data_ready from the slave gates acceptance of data_in.
interface seq_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/seq_serializer_piso.sv
// WIDTH-bit parallel-load / serial-shift register; bit_out is the bit currently on the line.
// Latency: a loaded word appears on bit_out the cycle after load.
// Backpressure: none; load has priority over shift.
module seq_piso_shreg #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             bit_out
);
    logic [WIDTH-1:0] sh_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q <= '0;
        end else if (load) begin
            sh_q <= data;
        end else if (shift) begin
            if (MSB_FIRST != 0) sh_q <= {sh_q[WIDTH-2:0], 1'b0};
            else                sh_q <= {1'b0, sh_q[WIDTH-1:1]};
        end
    end

    assign bit_out = (MSB_FIRST != 0) ? sh_q[WIDTH-1] : sh_q[0];
endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial stage feeding the "101" detector: one word in, one bit per clock out.
// Latency: word accepted at edge k is on seq_out in cycles k+1..k+WIDTH.
// Backpressure: one-word pending register; data_ready drops only while it holds a word.
module seq_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = IDLE_BIT_DEF,
    parameter int   CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    seq_serializer_if.slave     in_if,
    output logic                seq_out,
    output logic                seq_valid,
    output logic                busy,
    output logic [CNT_W-1:0]    words_sent,
    output logic [STATE_W-1:0]  state_out
);
    localparam int              BC_W    = $clog2(WIDTH);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] pend_q;
    logic             pend_full_q;
    logic [CNT_W-1:0] words_q;
    logic             seq_valid_q;

    logic             accept;
    logic             last_bit;
    logic             sh_load;
    logic             sh_shift;
    logic [WIDTH-1:0] sh_data;
    logic             sh_bit;
    logic             pend_cap;
    logic             word_done;

    assign accept   = in_if.data_valid & ~pend_full_q;
    assign last_bit = (bit_cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        sh_data   = in_if.data_in;
        pend_cap  = 1'b0;
        word_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_load   = 1'b1;
                    bit_cnt_d = BC_LAST;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    word_done = 1'b1;
                    if (accept) begin
                        sh_load   = 1'b1;
                        bit_cnt_d = BC_LAST;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    sh_shift  = 1'b1;
                    bit_cnt_d = bit_cnt_q - BC_W'(1);
                    if (accept) begin
                        pend_cap = 1'b1;
                        state_d  = SHIFT_PEND;
                    end
                end
            end
            SHIFT_PEND: begin
                // No accept possible here; the pending word follows the last bit with no gap.
                if (last_bit) begin
                    word_done = 1'b1;
                    sh_load   = 1'b1;
                    sh_data   = pend_q;
                    bit_cnt_d = BC_LAST;
                    state_d   = SHIFT;
                end else begin
                    sh_shift  = 1'b1;
                    bit_cnt_d = bit_cnt_q - BC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            words_q     <= '0;
            seq_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            pend_full_q <= (state_d == SHIFT_PEND);
            seq_valid_q <= (state_d != IDLE);
            if (pend_cap)  pend_q  <= in_if.data_in;
            if (word_done) words_q <= words_q + CNT_W'(1);
        end
    end

    seq_piso_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .load    (sh_load),
        .shift   (sh_shift),
        .data    (sh_data),
        .bit_out (sh_bit)
    );

    assign in_if.data_ready = ~pend_full_q;
    assign seq_valid        = seq_valid_q;
    assign seq_out          = seq_valid_q ? sh_bit : IDLE_BIT;
    assign busy             = (state_q != IDLE);
    assign words_sent       = words_q;
    assign state_out        = state_q;
endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: two instances (MSB-first/16-bit count, LSB-first/2-bit count)
// checked every cycle against a queue-of-bits reference model.
module tb_seq_serializer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_serializer_if #(.WIDTH(W)) bus0 ();
    seq_serializer_if #(.WIDTH(W)) bus1 ();

    logic        so0, sv0, bs0, so1, sv1, bs1;
    logic [15:0] ws0;
    logic [1:0]  ws1, st0, st1;

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_BIT(1'b0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .in_if(bus0), .seq_out(so0), .seq_valid(sv0),
        .busy(bs0), .words_sent(ws0), .state_out(st0));

    seq_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_BIT(1'b0), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .in_if(bus1), .seq_out(so1), .seq_valid(sv1),
        .busy(bs1), .words_sent(ws1), .state_out(st1));

    // Reference model: each entry is {last_bit_of_word, bit}; the front entry is on the line.
    logic [1:0]  bq [2][$];
    int unsigned words [2];
    logic        acc_flag [2];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;

    // Observed stream helpers for the directed checks.
    logic [31:0] obs_bits0, obs_bits1;
    int          obs_cnt0, obs_cnt1, ready_low0, det_cnt, det_cyc;
    logic [2:0]  hist;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int i, input logic dv, input logic [W-1:0] din);
        int unsigned sz;
        logic [1:0]  e;
        int          idx;
        sz = bq[i].size();
        acc_flag[i] = 1'b0;
        if (rst) begin
            bq[i].delete();
            words[i] = 0;
        end else begin
            acc_flag[i] = dv && (sz <= W);
            if (sz > 0) begin
                e = bq[i].pop_front();
                if (e[1]) words[i] = (words[i] + 1) % ((i == 0) ? 65536 : 4);
            end
            if (acc_flag[i]) begin
                for (int j = 0; j < W; j++) begin
                    idx = (i == 0) ? (W - 1 - j) : j;
                    bq[i].push_back({(j == W - 1), din[idx]});
                end
            end
        end
    endtask

    task automatic check_dut(input int i, input logic sv, input logic so, input logic dr,
                             input logic bs, input logic [1:0] st, input logic [15:0] ws);
        int unsigned sz;
        string       p;
        logic [1:0]  f;
        sz = bq[i].size();
        p  = (i == 0) ? "u0" : "u1";
        f  = (sz > 0) ? bq[i][0] : 2'b00;
        chk({p, "_seq_valid"},  {31'd0, sv}, {31'd0, (sz > 0)});
        chk({p, "_seq_out"},    {31'd0, so}, {31'd0, f[0]});
        chk({p, "_data_ready"}, {31'd0, dr}, {31'd0, (sz <= W)});
        chk({p, "_busy"},       {31'd0, bs}, {31'd0, (sz > 0)});
        chk({p, "_state_out"},  {30'd0, st}, (sz == 0) ? 32'd0 : (sz <= W) ? 32'd1 : 32'd2);
        chk({p, "_words_sent"}, {16'd0, ws}, words[i]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0, bus0.data_valid, bus0.data_in);
        model_edge(1, bus1.data_valid, bus1.data_in);
        #1;
        cyc++;
        check_dut(0, sv0, so0, bus0.data_ready, bs0, st0, ws0);
        check_dut(1, sv1, so1, bus1.data_ready, bs1, st1, {14'd0, ws1});
        if (sv0) begin obs_bits0 = {obs_bits0[30:0], so0}; obs_cnt0++; end
        if (sv1) begin obs_bits1 = {obs_bits1[30:0], so1}; obs_cnt1++; end
        if (!bus0.data_ready) ready_low0++;
        hist = {hist[1:0], so0};
        if (hist == 3'b101) begin det_cnt++; det_cyc = cyc; end
    endtask

    task automatic send(input int i, input logic [W-1:0] w);
        bit done;
        done = 1'b0;
        if (i == 0) begin bus0.data_valid = 1'b1; bus0.data_in = w; end
        else        begin bus1.data_valid = 1'b1; bus1.data_in = w; end
        for (int t = 0; t < 40 && !done; t++) begin
            step();
            done = acc_flag[i];
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        if (i == 0) bus0.data_valid = 1'b0;
        else        bus1.data_valid = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        for (int t = 0; t < 60 && bq[i].size() != 0; t++) step();
        if (bq[i].size() != 0) chk("idle_timeout", 32'd0, 32'd1);
        step();
    endtask

    task automatic clear_obs();
        obs_bits0 = '0; obs_bits1 = '0; obs_cnt0 = 0; obs_cnt1 = 0; ready_low0 = 0;
    endtask

    int unsigned base;
    int          acc_cyc;

    initial begin
        bus0.data_valid = 1'b0; bus0.data_in = '0;
        bus1.data_valid = 1'b0; bus1.data_in = '0;
        hist = '0; det_cnt = 0; det_cyc = 0;
        clear_obs();

        // Reset held for two cycles.
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_seq_valid", {31'd0, sv0}, 32'd0);
        chk("rst_data_ready", {31'd0, bus0.data_ready}, 32'd1);
        chk("rst_words", {16'd0, ws0}, 32'd0);
        step();

        // Single word, MSB first.
        clear_obs();
        send(0, 8'hA5);
        wait_idle(0);
        chk("t2_bits", obs_bits0, 32'h0000_00A5);
        chk("t2_valid_cycles", obs_cnt0, 32'd8);
        chk("t2_words", {16'd0, ws0}, 32'd1);

        // Two words back to back; second waits in the pending register.
        clear_obs();
        base = words[0];
        send(0, 8'hB5);
        send(0, 8'hCA);
        chk("t3_state_pend", {30'd0, st0}, 32'd2);
        wait_idle(0);
        chk("t3_bits", obs_bits0, 32'h0000_B5CA);
        chk("t3_valid_cycles", obs_cnt0, 32'd16);
        chk("t3_ready_low", ready_low0, 32'd7);
        chk("t3_words", words[0] - base, 32'd2);
        chk("t3_words_dut", {16'd0, ws0} - base, 32'd2);

        // Detector downstream sees exactly one "101" for 8'h05, on the final bit.
        for (int t = 0; t < 4; t++) step();
        det_cnt = 0;
        send(0, 8'h05);
        acc_cyc = cyc;
        wait_idle(0);
        for (int t = 0; t < 4; t++) step();
        chk("t4_det_count", det_cnt, 32'd1);
        chk("t4_det_cycle", det_cyc - acc_cyc, 32'd7);

        // Reset mid-word drops both the active and pending words.
        clear_obs();
        send(0, 8'hFF);
        bus0.data_valid = 1'b1; bus0.data_in = 8'h00;
        step();
        bus0.data_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_seq_valid", {31'd0, sv0}, 32'd0);
        chk("t5_data_ready", {31'd0, bus0.data_ready}, 32'd1);
        chk("t5_state", {30'd0, st0}, 32'd0);
        chk("t5_words", {16'd0, ws0}, 32'd0);
        for (int t = 0; t < 12; t++) step();
        chk("t5_bits_seen", obs_cnt0, 32'd3);

        // LSB first on u1, then 2-bit counter wrap after four words.
        clear_obs();
        send(1, 8'h01);
        wait_idle(1);
        chk("t6_bits", obs_bits1, 32'h0000_0080);
        chk("t6_words1", {30'd0, ws1}, 32'd1);
        send(1, 8'h3C); send(1, 8'hC3); send(1, 8'h7E);
        wait_idle(1);
        chk("t6_wrap", {30'd0, ws1}, 32'd0);

        // Random traffic on both instances with occasional resets.
        for (int t = 0; t < 600; t++) begin
            bus0.data_valid = ($urandom_range(0, 3) != 0);
            bus0.data_in    = W'($urandom);
            bus1.data_valid = ($urandom_range(0, 2) == 0);
            bus1.data_in    = W'($urandom);
            rst             = ($urandom_range(0, 150) == 0);
            step();
        end
        rst = 1'b0;
        bus0.data_valid = 1'b0;
        bus1.data_valid = 1'b0;
        wait_idle(0);
        wait_idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
